// File: rtl/temp_calc_pkg.sv
// temp_calc_pkg: shared types and width helpers for the sequential
// temperature calculator.
//   state_t   - controller states (IDLE, MUL, ADD, DONE)
//   ch_width  - channel index width, never less than 1
//   fw_width  - width of the final base + scaled-product sum
package temp_calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_t;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Wide enough for base + (prod >> fs) without loss, plus a carry bit.
  function automatic int unsigned fw_width(input int unsigned bw,
                                           input int unsigned sw,
                                           input int unsigned cw,
                                           input int unsigned fs);
    int unsigned pw;
    pw = sw + cw - fs;
    return ((bw > pw) ? bw : pw) + 1;
  endfunction

endpackage

// File: rtl/temp_calc_seq_mult.sv
// shift_add_mult: SW x CW unsigned sequential multiplier.
//   clk, rst_n : clock, synchronous active-low reset (aborts a multiply)
//   start      : load operands a/b and clear the accumulator
//   a, b       : multiplicand (SW bits), multiplier (CW bits)
//   last       : high during the final of the CW iteration cycles
//   prod       : accumulator; holds the full product once last has passed
// One multiplier bit is consumed per cycle, LSB first.
module shift_add_mult #(
  parameter int unsigned SW = 4,
  parameter int unsigned CW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SW-1:0]    a,
  input  logic [CW-1:0]    b,
  output logic             last,
  output logic [SW+CW-1:0] prod
);

  localparam int unsigned PW   = SW + CW;
  localparam int unsigned CNTW = (CW > 1) ? $clog2(CW) : 1;

  logic [PW-1:0]   mcand;
  logic [CW-1:0]   mplier;
  logic [CNTW-1:0] cnt;
  logic            busy;

  assign last = busy && (cnt == CNTW'(CW - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
      prod   <= '0;
    end else if (busy) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/temp_calc_seq.sv
// temp_calc_seq: multi-channel temperature calculator,
//   temp = base[ch] + ((sensor * coef[ch]) >> FRAC_SHIFT)
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cfg_we/cfg_ch/cfg_base/cfg_coef  calibration write (ignored if ch >= NCH)
//   in_valid/in_ready/in_ch/in_sensor  request handshake
//   out_valid/out_ready/out_ch/out_temp/out_ovf  result handshake
// One request in flight: IDLE -> MUL (CW cycles) -> ADD -> DONE.
// Build option: define TEMP_SAT_EN to saturate out_temp to all ones on
// overflow; otherwise the sum wraps. out_ovf is the same in both builds.
module temp_calc_seq
  import temp_calc_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned SW         = 4,
  parameter int unsigned CW         = 4,
  parameter int unsigned BW         = 5,
  parameter int unsigned FRAC_SHIFT = 3,
  parameter int unsigned OW         = 8,
  localparam int unsigned CHW       = ch_width(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [BW-1:0]  cfg_base,
  input  logic [CW-1:0]  cfg_coef,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [SW-1:0]  in_sensor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [OW-1:0]  out_temp,
  output logic           out_ovf
);

  localparam int unsigned NSLOT = 1 << CHW;
  localparam int unsigned FW    = fw_width(BW, SW, CW, FRAC_SHIFT);

  state_t state, state_next;

  // Slots at or above NCH are never written, so they read back as zero,
  // which gives out-of-range requests a zero base and coefficient.
  logic [BW-1:0] base_rf [NSLOT];
  logic [CW-1:0] coef_rf [NSLOT];

  logic           accept;
  logic           mul_last;
  logic [SW+CW-1:0] prod;
  logic [CHW-1:0] ch_q;
  logic [BW-1:0]  base_q;
  logic [FW-1:0]  sum;
  logic [OW-1:0]  temp_next;
  logic           ovf_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        base_rf[i] <= '0;
        coef_rf[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < NCH)) begin
      base_rf[cfg_ch] <= cfg_base;
      coef_rf[cfg_ch] <= cfg_coef;
    end
  end

  assign accept = in_valid && in_ready;

  shift_add_mult #(
    .SW(SW),
    .CW(CW)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .a     (in_sensor),
    .b     (coef_rf[in_ch]),
    .last  (mul_last),
    .prod  (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        if (mul_last) state_next = ADD;
      end
      ADD: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum = FW'(base_q) + FW'(prod >> FRAC_SHIFT);

  generate
    if (OW >= FW) begin : g_wide
      assign ovf_next  = 1'b0;
      assign temp_next = OW'(sum);
    end else begin : g_narrow
      assign ovf_next = |sum[FW-1:OW];
`ifdef TEMP_SAT_EN
      assign temp_next = ovf_next ? '1 : sum[OW-1:0];
`else
      assign temp_next = sum[OW-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q     <= '0;
      base_q   <= '0;
      out_ch   <= '0;
      out_temp <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        ch_q   <= in_ch;
        base_q <= base_rf[in_ch];
      end
      if (state == ADD) begin
        out_ch   <= ch_q;
        out_temp <= temp_next;
        out_ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_temp_calc_seq.sv
// tb_temp_calc_seq: drives two temp_calc_seq instances with identical
// stimulus (default parameters, and NCH=3 / OW=5) and compares both
// against an arithmetic reference model of the calibration table.
module tb_temp_calc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [4:0] cfg_base;
  logic [3:0] cfg_coef;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [3:0] in_sensor;
  logic       out_ready;

  logic       rdy_a, vld_a, ovf_a;
  logic [1:0] och_a;
  logic [7:0] temp_a;
  logic       rdy_b, vld_b, ovf_b;
  logic [1:0] och_b;
  logic [4:0] temp_b;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned mb_a [4];
  int unsigned mc_a [4];
  int unsigned mb_b [4];
  int unsigned mc_b [4];

  always #5 clk = ~clk;

  temp_calc_seq u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_coef(cfg_coef),
    .in_valid(in_valid), .in_ready(rdy_a), .in_ch(in_ch), .in_sensor(in_sensor),
    .out_valid(vld_a), .out_ready(out_ready), .out_ch(och_a),
    .out_temp(temp_a), .out_ovf(ovf_a)
  );

  temp_calc_seq #(.NCH(3), .OW(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_coef(cfg_coef),
    .in_valid(in_valid), .in_ready(rdy_b), .in_ch(in_ch), .in_sensor(in_sensor),
    .out_valid(vld_b), .out_ready(out_ready), .out_ch(och_b),
    .out_temp(temp_b), .out_ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int unsigned base, input int unsigned coef,
                                input int unsigned sensor, input int unsigned ow,
                                output int unsigned temp, output int unsigned ovf);
    int unsigned sum, mx;
    sum = base + ((sensor * coef) / 8);
    mx  = (1 << ow) - 1;
    ovf = (sum > mx) ? 1 : 0;
`ifdef TEMP_SAT_EN
    temp = (ovf != 0) ? mx : sum;
`else
    temp = sum % (mx + 1);
`endif
  endfunction

  task automatic apply_cfg(input int unsigned ch, input int unsigned base, input int unsigned coef);
    mb_a[ch] = base;
    mc_a[ch] = coef;
    if (ch < 3) begin
      mb_b[ch] = base;
      mc_b[ch] = coef;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mb_a[i] = 0; mc_a[i] = 0; mb_b[i] = 0; mc_b[i] = 0;
    end
  endtask

  // Called and returns at a negedge.
  task automatic cfg_write(input int unsigned ch, input int unsigned base, input int unsigned coef);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_base = 5'(base);
    cfg_coef = 4'(coef);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    apply_cfg(ch, base, coef);
  endtask

  // One request. cfg_at >= 0 drives a calibration write at negedge n=cfg_at
  // (0 = on the accepting edge); rst_mid asserts reset in MUL cycle 2.
  task automatic request(input int unsigned ch, input int unsigned sensor, input int unsigned hold,
                         input int cfg_at, input int unsigned cch, input int unsigned cbase,
                         input int unsigned ccoef, input bit rst_mid);
    int unsigned ta, oa, tb, ob;
    model(mb_a[ch], mc_a[ch], sensor, 8, ta, oa);
    model((ch < 3) ? mb_b[ch] : 0, (ch < 3) ? mc_b[ch] : 0, sensor, 5, tb, ob);
    out_ready = (hold == 0);
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (cfg_at >= 0 && n == cfg_at + 1) begin
        cfg_we = 1'b0;
        apply_cfg(cch, cbase, ccoef);
      end
      if (cfg_at >= 0 && n == cfg_at) begin
        cfg_we   = 1'b1;
        cfg_ch   = 2'(cch);
        cfg_base = 5'(cbase);
        cfg_coef = 4'(ccoef);
      end
      if (n == 0) begin
        in_valid  = 1'b1;
        in_ch     = 2'(ch);
        in_sensor = 4'(sensor);
        check("idle_rdy_a", 32'(rdy_a), 1);
        check("idle_rdy_b", 32'(rdy_b), 1);
      end else if (n < 6) begin
        // in_valid stays high with junk data: must not be taken while busy
        in_sensor = 4'($urandom);
        check("busy_vld_a", 32'(vld_a), 0);
        check("busy_rdy_a", 32'(rdy_a), 0);
        check("busy_vld_b", 32'(vld_b), 0);
        check("busy_rdy_b", 32'(rdy_b), 0);
        if (rst_mid && n == 2) begin
          rst_n    = 1'b0;
          in_valid = 1'b0;
          out_ready = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check("rst_rdy_a",  32'(rdy_a), 1);
          check("rst_vld_a",  32'(vld_a), 0);
          check("rst_temp_a", 32'(temp_a), 0);
          check("rst_ch_a",   32'(och_a), 0);
          check("rst_ovf_a",  32'(ovf_a), 0);
          check("rst_vld_b",  32'(vld_b), 0);
          check("rst_temp_b", 32'(temp_b), 0);
          rst_n = 1'b1;
          clear_model();
          return;
        end
      end else begin
        check("res_vld_a",  32'(vld_a), 1);
        check("res_temp_a", 32'(temp_a), ta);
        check("res_ch_a",   32'(och_a), ch);
        check("res_ovf_a",  32'(ovf_a), oa);
        check("res_vld_b",  32'(vld_b), 1);
        check("res_temp_b", 32'(temp_b), tb);
        check("res_ch_b",   32'(och_b), ch);
        check("res_ovf_b",  32'(ovf_b), ob);
      end
    end
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_vld_a",  32'(vld_a), 1);
      check("hold_temp_a", 32'(temp_a), ta);
      check("hold_rdy_a",  32'(rdy_a), 0);
      check("hold_temp_b", 32'(temp_b), tb);
      check("hold_ovf_b",  32'(ovf_b), ob);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rel_vld_a", 32'(vld_a), 0);
    check("rel_rdy_a", 32'(rdy_a), 1);
    check("rel_vld_b", 32'(vld_b), 0);
    check("rel_rdy_b", 32'(rdy_b), 1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_coef = '0;
    in_valid = 1'b0; in_ch = '0; in_sensor = '0; out_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_rdy_a",  32'(rdy_a), 1);
    check("init_vld_a",  32'(vld_a), 0);
    check("init_temp_a", 32'(temp_a), 0);
    check("init_ch_a",   32'(och_a), 0);
    check("init_ovf_a",  32'(ovf_a), 0);
    check("init_vld_b",  32'(vld_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    cfg_write(0, 20, 5);
    request(0, 9, 0, -1, 0, 0, 0, 0);
    request(0, 9, 10, -1, 0, 0, 0, 0);
    cfg_write(2, 10, 2);
    request(2, 8, 0, 2, 2, 10, 15, 0);
    request(2, 8, 0, -1, 0, 0, 0, 0);
    cfg_write(1, 31, 15);
    request(1, 15, 2, -1, 0, 0, 0, 0);
    cfg_write(3, 7, 7);
    request(3, 15, 0, -1, 0, 0, 0, 0);
    request(1, 3, 0, 0, 1, 4, 9, 0);
    request(1, 3, 0, -1, 0, 0, 0, 0);
    request(1, 15, 0, -1, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) request(c, 15, 0, -1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 15));
      end else begin
        request($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                int'($urandom_range(0, 6)) - 1, $urandom_range(0, 3),
                $urandom_range(0, 31), $urandom_range(0, 15), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
